// File: rtl/fc_pkg.sv
// Shared constants for the fast-control sequencer.
// Channel indices name the bit positions of the unencoded fast-control word.
// The default widths are used as parameter defaults by fast_control_seq and its sub-modules.
package fc_pkg;

    // Bit positions in the fast-control word
    localparam int unsigned FC_BCR          = 0;
    localparam int unsigned FC_L1A          = 1;
    localparam int unsigned FC_LINK_RESET   = 2;
    localparam int unsigned FC_BUFFER_CLEAR = 3;

    // Default widths
    localparam int unsigned FC_WORD_BITS_DEF = 8;
    localparam int unsigned FC_N_CMD_DEF     = 4;
    localparam int unsigned FC_BX_W_DEF      = 12;
    localparam int unsigned FC_PEND_W_DEF    = 2;
    localparam int unsigned FC_GAP_W_DEF     = 8;

endpackage

// File: rtl/fc_cmd_channel.sv
// One requestable fast-control channel.
// It holds the pending-request counter, the sticky overflow flag and the eligibility decision.
// An optional holdoff timer enforces a minimum spacing between fires; the L1A channel uses it.
//   clk_bx, reset_n  : BX clock, async active-low reset
//   req              : 1-cycle request pulse
//   align, at_align  : fire only when at_align is high (if align is set)
//   enable           : global gate for requestable channels
//   clear_pend       : clear pending count and overflow flag
//   l1a_gap          : minimum fire spacing in BX (holdoff channels only)
//   fire             : command bit for the word being built this cycle
//   ovf              : sticky overflow flag
module fc_cmd_channel
    import fc_pkg::*;
#(
    parameter int unsigned PEND_W     = FC_PEND_W_DEF,
    parameter int unsigned GAP_W      = FC_GAP_W_DEF,
    parameter bit          HOLDOFF_EN = 1'b0
) (
    input  logic             clk_bx,
    input  logic             reset_n,
    input  logic             req,
    input  logic             align,
    input  logic             at_align,
    input  logic             enable,
    input  logic             clear_pend,
    input  logic [GAP_W-1:0] l1a_gap,
    output logic             fire,
    output logic             ovf
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [PEND_W-1:0] pend_q, pend_d;
    logic [GAP_W-1:0]  holdoff_q, holdoff_d;
    logic              ovf_q, ovf_d;

    // Eligibility looks only at registered pend, so a request can never fire in its own cycle
    always_comb begin
        fire = (pend_q != '0) && enable && (!align || at_align)
               && (!HOLDOFF_EN || (holdoff_q == '0));
    end

    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (clear_pend) begin
            pend_d = '0;
            ovf_d  = 1'b0;
        end else if (req && !fire) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (!req && fire) begin
            pend_d = pend_q - 1'b1;
        end
    end

    // Loading gap-1 on a fire at BX n releases the next fire at BX n+gap
    always_comb begin
        holdoff_d = holdoff_q;
        if (fire) begin
            holdoff_d = (l1a_gap == '0) ? '0 : l1a_gap - 1'b1;
        end else if (holdoff_q != '0) begin
            holdoff_d = holdoff_q - 1'b1;
        end
    end

    always_ff @(posedge clk_bx or negedge reset_n) begin
        if (!reset_n) begin
            pend_q    <= '0;
            holdoff_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            holdoff_q <= holdoff_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ovf = ovf_q;

endmodule

// File: rtl/hamming84_enc.sv
// Hamming(8,4) encoder for a single nibble (SECDED).
// Codeword positions 1..7 map to code[0..6] as p1, p2, d0, p3, d1, d2, d3.
// code[7] is the overall parity of code[6:0].
//   data  in  4: nibble to encode
//   code  out 8: encoded byte
module hamming84_enc (
    input  logic [3:0] data,
    output logic [7:0] code
);

    logic p1, p2, p3;

    assign p1 = data[0] ^ data[1] ^ data[3];
    assign p2 = data[0] ^ data[2] ^ data[3];
    assign p3 = data[1] ^ data[2] ^ data[3];

    assign code[6:0] = {data[3], data[2], data[1], p3, data[0], p2, p1};
    assign code[7]   = ^code[6:0];

endmodule

// File: rtl/fast_control_seq.sv
// Fast-control sequencer and encoder.
// It runs a BX counter, builds one fast-control word per BX and Hamming(8,4)-encodes it per nibble.
// Word contents are BCR at BX 0, queued channel commands and quasi-static upper bits.
//   clk_bx, reset_n : BX clock, async active-low reset
//   orb_length      : orbit length in BX (0 = natural wrap)
//   cmd_req         : request pulses, bit k -> channel k+1
//   cmd_align       : per-channel fire-only-at-align_bx
//   align_bx        : BX slot for aligned channels
//   l1a_gap         : minimum L1A spacing in BX
//   enable          : gate for requestable channels
//   clear_pend      : clear pending counters and overflow flags
//   static_bits     : upper word bits
//   bx_counter      : current BX
//   fc_word         : registered unencoded word (tagged with previous bx_counter)
//   fc_stream_enc   : registered encoded word (one cycle after fc_word)
//   pend_ovf        : sticky per-channel overflow
//   l1a_count       : emitted L1A count, wraps
module fast_control_seq
    import fc_pkg::*;
#(
    parameter int unsigned WORD_BITS = FC_WORD_BITS_DEF,
    parameter int unsigned N_CMD     = FC_N_CMD_DEF,
    parameter int unsigned BX_W      = FC_BX_W_DEF,
    parameter int unsigned PEND_W    = FC_PEND_W_DEF,
    parameter int unsigned GAP_W     = FC_GAP_W_DEF
) (
    input  logic                      clk_bx,
    input  logic                      reset_n,
    input  logic [BX_W-1:0]           orb_length,
    input  logic [N_CMD-2:0]          cmd_req,
    input  logic [N_CMD-2:0]          cmd_align,
    input  logic [BX_W-1:0]           align_bx,
    input  logic [GAP_W-1:0]          l1a_gap,
    input  logic                      enable,
    input  logic                      clear_pend,
    input  logic [WORD_BITS-N_CMD-1:0] static_bits,
    output logic [BX_W-1:0]           bx_counter,
    output logic [WORD_BITS-1:0]      fc_word,
    output logic [2*WORD_BITS-1:0]    fc_stream_enc,
    output logic [N_CMD-2:0]          pend_ovf,
    output logic [31:0]               l1a_count
);

    localparam int unsigned N_NIB = WORD_BITS / 4;

    logic [BX_W-1:0]        bx_counter_q, bx_counter_d;
    logic [BX_W:0]          bx_inc;
    logic [WORD_BITS-1:0]   fc_word_q, fc_word_d;
    logic [2*WORD_BITS-1:0] fc_stream_enc_q, fc_stream_enc_d;
    logic [31:0]            l1a_count_q, l1a_count_d;
    logic [N_CMD-2:0]       fire;
    logic                   at_align;

    // One extra bit keeps the wrap compare correct when orb_length is near 2^BX_W
    assign bx_inc = {1'b0, bx_counter_q} + 1'b1;

    always_comb begin
        bx_counter_d = bx_inc[BX_W-1:0];
        if ((orb_length != '0) && (bx_inc >= {1'b0, orb_length})) begin
            bx_counter_d = '0;
        end
    end

    assign at_align = (bx_counter_q == align_bx);

    for (genvar c = 0; c < N_CMD - 1; c++) begin : g_ch
        fc_cmd_channel #(
            .PEND_W     (PEND_W),
            .GAP_W      (GAP_W),
            .HOLDOFF_EN (c + 1 == FC_L1A)
        ) u_ch (
            .clk_bx     (clk_bx),
            .reset_n    (reset_n),
            .req        (cmd_req[c]),
            .align      (cmd_align[c]),
            .at_align   (at_align),
            .enable     (enable),
            .clear_pend (clear_pend),
            .l1a_gap    (l1a_gap),
            .fire       (fire[c]),
            .ovf        (pend_ovf[c])
        );
    end

    // Word built this cycle is tagged with the current bx_counter
    always_comb begin
        fc_word_d   = {static_bits, fire, (bx_counter_q == '0)};
        l1a_count_d = l1a_count_q + 32'(fire[FC_L1A-1]);
    end

    for (genvar i = 0; i < N_NIB; i++) begin : g_enc
        hamming84_enc u_enc (
            .data (fc_word_q[4*i +: 4]),
            .code (fc_stream_enc_d[8*i +: 8])
        );
    end

    always_ff @(posedge clk_bx or negedge reset_n) begin
        if (!reset_n) begin
            bx_counter_q    <= '0;
            fc_word_q       <= '0;
            fc_stream_enc_q <= '0;
            l1a_count_q     <= '0;
        end else begin
            bx_counter_q    <= bx_counter_d;
            fc_word_q       <= fc_word_d;
            fc_stream_enc_q <= fc_stream_enc_d;
            l1a_count_q     <= l1a_count_d;
        end
    end

    assign bx_counter    = bx_counter_q;
    assign fc_word       = fc_word_q;
    assign fc_stream_enc = fc_stream_enc_q;
    assign l1a_count     = l1a_count_q;

endmodule
